// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding select values and the
// MDU scoreboard state type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_RUN  = 1'b1
    } sb_state_e;

    // M beats W when both stages hold the same live destination.
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m)      return FWD_MEM;
        else if (hit_w) return FWD_WB;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_mdu.sv
// mdu_scoreboard: tracks one in-flight multi-cycle MDU operation, its
// destination register and the countdown to its completion strobe.
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [REG_W-1:0] dst_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [REG_W-1:0] busy_reg_o
);

    sb_state_e        state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [REG_W-1:0] busy_reg_q, busy_reg_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        busy_reg_d = busy_reg_q;
        case (state_q)
            SB_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d    = SB_RUN;
                    count_d    = 4'(MDU_LAT);
                    busy_reg_d = dst_i;
                end
            end
            SB_RUN: begin
                // A new start while running is dropped; the op in flight owns the unit.
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = SB_IDLE;
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SB_IDLE;
            count_q    <= '0;
            busy_reg_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            busy_reg_q <= busy_reg_d;
        end
    end

    assign busy_o     = (state_q == SB_RUN);
    assign done_o     = (state_q == SB_RUN) && (count_q == 4'd1);
    assign busy_reg_o = busy_reg_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/MDU stalls.
// Define HAZARD_PERF_EN to add saturating stall-cycle counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 4
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] WriteRegD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             MduStartD,
    input  logic             MduStartE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             MduBusy,
    output logic             MduDone
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] LwStallCnt,
    output logic [CNT_W-1:0] BrStallCnt,
    output logic [CNT_W-1:0] MduStallCnt
`endif
);

    logic             sb_busy, sb_done;
    logic [REG_W-1:0] busy_reg;
    logic             lw_stall, br_stall, mdu_stall, stall;

    always_comb begin
        ForwardAE = fwd_sel((rsE != '0) && (rsE == WriteRegM) && RegWriteM,
                            (rsE != '0) && (rsE == WriteRegW) && RegWriteW);
        ForwardBE = fwd_sel((rtE != '0) && (rtE == WriteRegM) && RegWriteM,
                            (rtE != '0) && (rtE == WriteRegW) && RegWriteW);
        ForwardAD = (rsD != '0) && (rsD == WriteRegM) && RegWriteM;
        ForwardBD = (rtD != '0) && (rtD == WriteRegM) && RegWriteM;
    end

    always_comb begin
        lw_stall  = MemtoRegE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
        br_stall  = BranchD &&
                    ((RegWriteE && (WriteRegE != '0) &&
                      ((WriteRegE == rsD) || (WriteRegE == rtD))) ||
                     (MemtoRegM && (WriteRegM != '0) &&
                      ((WriteRegM == rsD) || (WriteRegM == rtD))));
        mdu_stall = sb_busy &&
                    (((busy_reg != '0) &&
                      ((busy_reg == rsD) || (busy_reg == rtD) || (busy_reg == WriteRegD))) ||
                     MduStartD);
        stall     = lw_stall || br_stall || mdu_stall;
    end

    // Outputs are masked during reset because the scoreboard flops only clear on the edge.
    assign StallF  = stall && !reset;
    assign StallD  = stall && !reset;
    assign FlushE  = stall && !reset;
    assign MduBusy = sb_busy && !reset;
    assign MduDone = sb_done && !reset;

    mdu_scoreboard #(
        .REG_W   (REG_W),
        .MDU_LAT (MDU_LAT)
    ) u_mdu_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .start_i    (MduStartE),
        .flush_i    (FlushE),
        .dst_i      (WriteRegE),
        .busy_o     (sb_busy),
        .done_o     (sb_done),
        .busy_reg_o (busy_reg)
    );

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lw_cnt_q, lw_cnt_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

    always_comb begin
        lw_cnt_d  = lw_cnt_q;
        br_cnt_d  = br_cnt_q;
        mdu_cnt_d = mdu_cnt_q;
        if (lw_stall  && !(&lw_cnt_q))  lw_cnt_d  = lw_cnt_q  + CNT_W'(1);
        if (br_stall  && !(&br_cnt_q))  br_cnt_d  = br_cnt_q  + CNT_W'(1);
        if (mdu_stall && !(&mdu_cnt_q)) mdu_cnt_d = mdu_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lw_cnt_q  <= '0;
            br_cnt_q  <= '0;
            mdu_cnt_q <= '0;
        end else begin
            lw_cnt_q  <= lw_cnt_d;
            br_cnt_q  <= br_cnt_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    assign LwStallCnt  = lw_cnt_q;
    assign BrStallCnt  = br_cnt_q;
    assign MduStallCnt = mdu_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table of combinational vectors
// plus MDU sequences with a queue of expected completion cycles.
module tb_hazard_scoreboard;

    localparam int MDU_LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, WriteRegD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
    logic       MduStartD, MduStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MduBusy, MduDone;
`ifdef HAZARD_PERF_EN
    logic [3:0] LwStallCnt, BrStallCnt, MduStallCnt;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hazard_scoreboard #(
        .REG_W   (5),
        .MDU_LAT (MDU_LAT)
`ifdef HAZARD_PERF_EN
        ,
        .CNT_W   (4)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rsD       (rsD),
        .rtD       (rtD),
        .WriteRegD (WriteRegD),
        .rsE       (rsE),
        .rtE       (rtE),
        .WriteRegE (WriteRegE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteE (RegWriteE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .MemtoRegE (MemtoRegE),
        .MemtoRegM (MemtoRegM),
        .BranchD   (BranchD),
        .MduStartD (MduStartD),
        .MduStartE (MduStartE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .MduBusy   (MduBusy),
        .MduDone   (MduDone)
`ifdef HAZARD_PERF_EN
        ,
        .LwStallCnt  (LwStallCnt),
        .BrStallCnt  (BrStallCnt),
        .MduStallCnt (MduStallCnt)
`endif
    );

    typedef struct {
        logic [4:0] rsD, rtD, rsE, rtE, WrE, WrM, WrW;
        logic       RWE, RWM, RWW, M2RE, M2RM, BrD;
        logic [1:0] fAE, fBE;
        logic       fAD, fBD, stall;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; WriteRegD = '0; rsE = '0; rtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
        MduStartD = 0; MduStartE = 0;
    endtask

    // Every MduDone must match the oldest outstanding expected completion cycle.
    always @(negedge clk) begin
        if (MduDone) begin
            if (exp_done_q.size() == 0) check("spurious_done", 1, 0);
            else check("done_cycle", cyc, exp_done_q.pop_front());
        end
    end

    initial begin
        //           rsD rtD rsE rtE WrE WrM WrW RWE RWM RWW M2RE M2RM BrD  fAE    fBE    fAD fBD st
        vecs[0]  = '{0,  0,  3,  0,  0,  3,  3,  0,  1,  1,  0,   0,   0,   2'b10, 2'b00, 0,  0,  0};
        vecs[1]  = '{0,  0,  3,  0,  0,  3,  3,  0,  0,  1,  0,   0,   0,   2'b01, 2'b00, 0,  0,  0};
        vecs[2]  = '{0,  0,  0,  0,  0,  3,  3,  0,  1,  1,  0,   0,   0,   2'b00, 2'b00, 0,  0,  0};
        vecs[3]  = '{0,  0,  2,  4,  0,  2,  4,  0,  1,  1,  0,   0,   0,   2'b10, 2'b01, 0,  0,  0};
        vecs[4]  = '{0,  0,  0,  4,  0,  4,  4,  0,  1,  1,  0,   0,   0,   2'b00, 2'b10, 0,  0,  0};
        vecs[5]  = '{5,  0,  0,  5,  0,  0,  0,  0,  0,  0,  1,   0,   0,   2'b00, 2'b00, 0,  0,  1};
        vecs[6]  = '{0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,   0,   0,   2'b00, 2'b00, 0,  0,  0};
        vecs[7]  = '{1,  5,  0,  5,  0,  0,  0,  0,  0,  0,  1,   0,   0,   2'b00, 2'b00, 0,  0,  1};
        vecs[8]  = '{5,  0,  0,  5,  0,  0,  0,  0,  0,  0,  0,   0,   0,   2'b00, 2'b00, 0,  0,  0};
        vecs[9]  = '{0,  7,  0,  0,  7,  0,  0,  1,  0,  0,  0,   0,   1,   2'b00, 2'b00, 0,  0,  1};
        vecs[10] = '{0,  7,  0,  0,  0,  7,  0,  0,  1,  0,  0,   1,   1,   2'b00, 2'b00, 0,  1,  1};
        vecs[11] = '{0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  0,   0,   1,   2'b00, 2'b00, 0,  0,  0};
        vecs[12] = '{0,  7,  0,  0,  7,  0,  0,  1,  0,  0,  0,   0,   0,   2'b00, 2'b00, 0,  0,  0};
        vecs[13] = '{6,  0,  0,  0,  0,  6,  0,  0,  1,  0,  0,   0,   0,   2'b00, 2'b00, 1,  0,  0};
        vecs[14] = '{0,  7,  0,  0,  7,  0,  0,  0,  0,  0,  0,   0,   1,   2'b00, 2'b00, 0,  0,  0};
        vecs[15] = '{0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,   1,   1,   2'b00, 2'b00, 0,  0,  0};

        // Reset: stalls masked even with a load-use pattern present; forwarding stays live.
        clear_inputs();
        reset = 1;
        MemtoRegE = 1; rtE = 5; rsD = 5;
        rsE = 3; WriteRegM = 3; RegWriteM = 1;
        step(); step();
        check("rst_StallF", StallF, 0);
        check("rst_FlushE", FlushE, 0);
        check("rst_MduBusy", MduBusy, 0);
        check("rst_MduDone", MduDone, 0);
        check("rst_ForwardAE", ForwardAE, 2);
        reset = 0;
        clear_inputs();
        step();

        foreach (vecs[i]) begin
            rsD = vecs[i].rsD; rtD = vecs[i].rtD; rsE = vecs[i].rsE; rtE = vecs[i].rtE;
            WriteRegE = vecs[i].WrE; WriteRegM = vecs[i].WrM; WriteRegW = vecs[i].WrW;
            RegWriteE = vecs[i].RWE; RegWriteM = vecs[i].RWM; RegWriteW = vecs[i].RWW;
            MemtoRegE = vecs[i].M2RE; MemtoRegM = vecs[i].M2RM; BranchD = vecs[i].BrD;
            #1;
            check($sformatf("v%0d_ForwardAE", i), ForwardAE, vecs[i].fAE);
            check($sformatf("v%0d_ForwardBE", i), ForwardBE, vecs[i].fBE);
            check($sformatf("v%0d_ForwardAD", i), ForwardAD, vecs[i].fAD);
            check($sformatf("v%0d_ForwardBD", i), ForwardBD, vecs[i].fBD);
            check($sformatf("v%0d_StallF", i), StallF, vecs[i].stall);
            check($sformatf("v%0d_StallD", i), StallD, vecs[i].stall);
            check($sformatf("v%0d_FlushE", i), FlushE, vecs[i].stall);
            step();
        end
        clear_inputs();
        step();

        // MDU op to r9 with rsD=9 held: stall through the done cycle, release after.
        MduStartE = 1; WriteRegE = 9; rsD = 9;
        #1;
        check("mdu_a_start_nostall", StallD, 0);
        exp_done_q.push_back(cyc + MDU_LAT);
        step();
        MduStartE = 0; WriteRegE = 0;
        for (int i = 1; i <= MDU_LAT; i++) begin
            #1;
            check($sformatf("mdu_a_busy%0d", i), MduBusy, 1);
            check($sformatf("mdu_a_stall%0d", i), StallD, 1);
            check($sformatf("mdu_a_done%0d", i), MduDone, (i == MDU_LAT) ? 1 : 0);
            step();
        end
        check("mdu_a_idle_busy", MduBusy, 0);
        check("mdu_a_idle_stall", StallD, 0);
        clear_inputs();
        step();

        // Second start while running is ignored; WriteRegD and MduStartD also stall.
        MduStartE = 1; WriteRegE = 9;
        exp_done_q.push_back(cyc + MDU_LAT);
        step();
        WriteRegE = 12; rsD = 12;
        #1;
        check("mdu_b_ign_stall", StallD, 0);
        step();
        MduStartE = 0; WriteRegE = 0;
        #1;
        check("mdu_b_busyreg_kept", StallD, 0);
        rsD = 0; WriteRegD = 9;
        #1;
        check("mdu_b_wrd_stall", StallD, 1);
        step();
        WriteRegD = 0; MduStartD = 1;
        #1;
        check("mdu_b_startd_stall", StallD, 1);
        step();
        MduStartD = 0;
        #1;
        check("mdu_b_done", MduDone, 1);
        check("mdu_b_done_nostall", StallD, 0);
        step();
        check("mdu_b_idle", MduBusy, 0);
        step();

        // A start coinciding with a flush must not launch.
        MduStartE = 1; WriteRegE = 9; MemtoRegE = 1; rtE = 5; rsD = 5;
        #1;
        check("mdu_c_flush", FlushE, 1);
        step();
        clear_inputs();
        #1;
        check("mdu_c_nostart", MduBusy, 0);
        step(); step();

        // Reset in the second RUN cycle aborts without a done strobe.
        MduStartE = 1; WriteRegE = 9;
        step();
        MduStartE = 0; WriteRegE = 0;
        #1;
        check("mdu_d_busy1", MduBusy, 1);
        step();
        reset = 1;
        #1;
        check("mdu_d_rst_busy", MduBusy, 0);
        step();
        reset = 0; rsD = 9;
        #1;
        check("mdu_d_abort_busy", MduBusy, 0);
        check("mdu_d_abort_stall", StallD, 0);
        for (int i = 0; i < 6; i++) step();
        clear_inputs();

`ifdef HAZARD_PERF_EN
        reset = 1;
        step();
        reset = 0; MemtoRegE = 1; rtE = 5; rsD = 5;
        for (int i = 0; i < 20; i++) step();
        check("cnt_lw_sat", LwStallCnt, 15);
        check("cnt_br_zero", BrStallCnt, 0);
        check("cnt_mdu_zero", MduStallCnt, 0);
        clear_inputs();
        step();
`endif

        check("done_pending", exp_done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_W, default 5: register-index width; index 0 is the hardwired zero register.
REQ-002 Parameter MDU_LAT, default 4: multi-cycle multiply/divide latency in cycles; legal range 1..15.
REQ-003 Parameter CNT_W, default 32: width of each performance counter.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rsD, rtD, WriteRegD  in  REG_W  source and destination indices of the D-stage instruction.
REQ-007 rsE, rtE, WriteRegE, WriteRegM, WriteRegW  in  REG_W  E-stage sources and the E/M/W destinations.
REQ-008 RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD  in  1  pipeline control.
REQ-009 MduStartD, MduStartE  in  1  a multi-cycle MDU instruction is in D or E.
REQ-010 ForwardAE, ForwardBE  out  2  E-stage operand select: 10 = M, 01 = W, 00 = register file.
REQ-011 ForwardAD, ForwardBD  out  1  D-stage branch comparator forward from M.
REQ-012 StallF, StallD, FlushE  out  1  freeze F/D and bubble E.
REQ-013 MduBusy, MduDone  out  1  MDU operation pending; one-cycle completion strobe.
REQ-014 LwStallCnt, BrStallCnt, MduStallCnt  out  CNT_W  stall-cycle counters; present only under HAZARD_PERF_EN.

Function
REQ-015 ForwardAE = 10 when rsE!=0, rsE==WriteRegM and RegWriteM; else 01 when rsE!=0, rsE==WriteRegW and RegWriteW; else 00. M has priority over W.
REQ-016 ForwardBE follows the same rule using rtE.
REQ-017 ForwardAD = (rsD!=0)&(rsD==WriteRegM)&RegWriteM; ForwardBD is the same rule using rtD.
REQ-018 lwstall = MemtoRegE & rtE!=0 & (rsD==rtE | rtD==rtE).
REQ-019 branchstall = BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE∈{rsD,rtD}) | (MemtoRegM & WriteRegM!=0 & WriteRegM∈{rsD,rtD})).
REQ-020 The scoreboard holds busy, a 4-bit countdown and a REG_W destination register BusyReg.
REQ-021 FSM states: IDLE (busy=0) and RUN (busy=1).
REQ-022 IDLE->RUN when MduStartE & ~FlushE: count<=MDU_LAT, BusyReg<=WriteRegE.
REQ-023 In RUN, count decrements each cycle.
REQ-024 MduDone=1 exactly in the RUN cycle with count==1; RUN->IDLE on the following edge.
REQ-025 MduStartE while already in RUN is ignored; the current operation continues unchanged.
REQ-026 mdustall = busy & ((BusyReg!=0 & BusyReg∈{rsD,rtD,WriteRegD}) | MduStartD), including the MduDone cycle.
REQ-027 StallF = StallD = FlushE = lwstall | branchstall | mdustall.
REQ-028 MduBusy = busy.
REQ-029 All forwarding and stall outputs are combinational from inputs and scoreboard state (zero-cycle latency).

Reset
REQ-030 While reset is high, StallF, StallD, FlushE, MduDone and MduBusy SHALL be 0; forwarding outputs still follow REQ-015..017.
REQ-031 On a reset edge: busy<=0, count<=0, BusyReg<=0, all counters<=0.
REQ-032 Reset during RUN aborts the operation; no MduDone is produced.

Configuration
REQ-033 With HAZARD_PERF_EN defined: LwStallCnt, BrStallCnt and MduStallCnt each increment once per cycle in which their stall term is 1, independently (overlaps count in each), and saturate at all-ones.
REQ-034 Without HAZARD_PERF_EN: the counter ports and logic are absent; all other behaviour is identical.

Structure
REQ-035 Package hazard_pkg holds the Forward encoding constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the scoreboard state enum.
REQ-036 The countdown scoreboard is one sub-module, mdu_scoreboard; forwarding and stall logic sit in the top level.

Verification
REQ-037 rsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> ForwardAE=10; drop RegWriteM -> 01; rsE=0 -> 00.
REQ-038 MemtoRegE=1, rtE=5, rsD=5 -> StallF=StallD=FlushE=1 for one cycle; rtE=0, rsD=0 -> no stall.
REQ-039 BranchD=1, RegWriteE=1, WriteRegE=rtD=7 -> stall; next cycle MemtoRegM=1, WriteRegM=7 -> stall again.
REQ-040 MDU_LAT=4, MduStartE, WriteRegE=9 -> MduBusy high for 4 cycles, MduDone in the 4th; rsD=9 throughout -> stall in all 4 cycles, released in the 5th.
REQ-041 Reset asserted in cycle 2 of RUN -> MduBusy=0 next cycle, MduDone never pulses; MduStartE during RUN -> BusyReg unchanged.
REQ-042 HAZARD_PERF_EN with CNT_W=4 and lwstall held for 20 cycles -> LwStallCnt=15 (saturated).
